// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends the right-aligned bytes of one header
// beat to the following payload packet and re-packs the merged byte stream
// into full-width output beats. Byte 0 on the wire is the MSB byte of data.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_in,
  input  logic [DATA_WD-1:0]              data_in,
  input  logic [DATA_BYTE_WD-1:0]         keep_in,
  input  logic                            last_in,
  output logic                            ready_in,
  input  logic                            valid_insert,
  input  logic [DATA_WD-1:0]              data_insert,
  input  logic [DATA_BYTE_WD-1:0]         keep_insert,
  input  logic [$clog2(DATA_BYTE_WD)-1:0] byte_insert_cnt,
  output logic                            ready_insert,
  output logic                            valid_out,
  output logic [DATA_WD-1:0]              data_out,
  output logic [DATA_BYTE_WD-1:0]         keep_out,
  output logic                            last_out,
  input  logic                            ready_out
);

  // Counts range over 0..DATA_BYTE_WD; sums of two counts need one more bit.
  localparam int CNT_W = $clog2(DATA_BYTE_WD + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BYTE_WD);
  localparam logic [CNT_W:0]   FULL_SUM = (CNT_W + 1)'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                    state, next_state;
  logic [DATA_WD-1:0]        resid, resid_d;
  logic [CNT_W-1:0]          rn, rn_d;
  logic                      load_out;
  logic [DATA_WD-1:0]        data_d;
  logic [DATA_BYTE_WD-1:0]   keep_d;
  logic                      last_d;
  logic                      out_free;
  logic [DATA_WD-1:0]        data_in_m;
  logic [CNT_W-1:0]          m_cnt, n_cnt, hdr_pad;
  logic [CNT_W:0]            sum_cnt;
  logic [2*DATA_WD-1:0]      wide;
  logic [DATA_WD-1:0]        hdr_aligned;
  logic                      unused_sideband;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_BYTE_WD-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // k ones starting from the MSB lane
  function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [CNT_W:0] k);
    return ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_WD-1:0] mask_bytes(input logic [DATA_WD-1:0] d,
                                                    input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) if (k[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // The byte-count sideband duplicates keep_insert and is not needed.
  assign unused_sideband = ^byte_insert_cnt;

  assign out_free  = !valid_out || ready_out;
  assign data_in_m = mask_bytes(data_in, keep_in);
  assign m_cnt     = popcount(keep_in);
  assign n_cnt     = popcount(keep_insert);
  assign sum_cnt   = {1'b0, rn} + {1'b0, m_cnt};
  assign hdr_pad   = FULL_CNT - n_cnt;

  // Residual bytes are kept MSB-aligned with zeros below them, so the merged
  // stream is the residual OR'd with the payload shifted down by rn bytes.
  assign wide        = {resid, {DATA_WD{1'b0}}} | ({data_in_m, {DATA_WD{1'b0}}} >> {rn, 3'b000});
  assign hdr_aligned = data_insert << {hdr_pad, 3'b000};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, handshake and next-output-beat decode
  always_comb begin
    next_state   = state;
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    load_out     = 1'b0;
    data_d       = '0;
    keep_d       = '0;
    last_d       = 1'b0;
    resid_d      = resid;
    rn_d         = rn;
    case (state)
      IDLE: begin
        ready_insert = rst_n;
        if (valid_insert && rst_n) begin
          resid_d    = hdr_aligned;
          rn_d       = n_cnt;
          next_state = STREAM;
        end
      end
      STREAM: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          load_out = 1'b1;
          data_d   = wide[2*DATA_WD-1:DATA_WD];
          if (!last_in) begin
            keep_d  = '1;
            resid_d = wide[DATA_WD-1:0];
          end else if (sum_cnt <= FULL_SUM) begin
            keep_d     = keep_msb(sum_cnt);
            last_d     = 1'b1;
            next_state = IDLE;
          end else begin
            keep_d     = '1;
            resid_d    = wide[DATA_WD-1:0];
            rn_d       = CNT_W'(sum_cnt - FULL_SUM);
            next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_out   = 1'b1;
          data_d     = resid;
          keep_d     = keep_msb({1'b0, rn});
          last_d     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Residual byte buffer carried between beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resid <= '0;
      rn    <= '0;
    end else begin
      resid <= resid_d;
      rn    <= rn_d;
    end
  end

  // Output register: only advances when empty or being taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (out_free) begin
      valid_out <= load_out;
      if (load_out) begin
        data_out <= data_d;
        keep_out <= keep_d;
        last_out <= last_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Bench for axi_stream_insert_header: packets are described as byte lists,
// the expected output is the header+payload byte stream re-chunked into beats.
module tb_axi_stream_insert_header;

  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_insert = 1'b0;
  logic [DW-1:0] data_insert = '0;
  logic [BW-1:0] keep_insert = '0;
  logic [1:0]    byte_insert_cnt = '0;
  logic          ready_insert;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          last_out;
  logic          ready_out = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t      hdr_q[$];
  beat_t      pay_q[$];
  beat_t      exp_q[$];
  logic [7:0] pay_bytes[$];

  int checks = 0;
  int fails  = 0;
  bit sb_en = 1'b1;
  bit hdr_done, pay_done;

  axi_stream_insert_header #(.DATA_WD(DW), .DATA_BYTE_WD(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  initial forever #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Append the top nb bytes of w to the pending payload byte list
  task automatic push_word(input logic [31:0] w, input int nb);
    for (int j = 0; j < nb; j++) pay_bytes.push_back(w[31-8*j -: 8]);
  endtask

  // Reference model: header bytes then payload bytes, cut into 4-byte beats
  task automatic add_packet(input logic [31:0] hd, input int n);
    logic [7:0] merged[$];
    beat_t      b;
    b = '{data: hd, keep: 4'((1 << n) - 1), last: 1'b0};
    hdr_q.push_back(b);
    for (int i = n - 1; i >= 0; i--) merged.push_back(hd[8*i +: 8]);
    foreach (pay_bytes[i]) merged.push_back(pay_bytes[i]);
    for (int s = 0; s < pay_bytes.size(); s += 4) begin
      b = '{data: 32'h0, keep: 4'h0, last: (s + 4 >= pay_bytes.size())};
      for (int j = 0; j < 4; j++)
        if (s + j < pay_bytes.size()) begin
          b.data[31-8*j -: 8] = pay_bytes[s+j];
          b.keep[3-j]         = 1'b1;
        end
      pay_q.push_back(b);
    end
    for (int s = 0; s < merged.size(); s += 4) begin
      b = '{data: 32'h0, keep: 4'h0, last: (s + 4 >= merged.size())};
      for (int j = 0; j < 4; j++)
        if (s + j < merged.size()) begin
          b.data[31-8*j -: 8] = merged[s+j];
          b.keep[3-j]         = 1'b1;
        end
      exp_q.push_back(b);
    end
    pay_bytes.delete();
  endtask

  task automatic add_random_packet();
    int n, plen;
    n    = int'($urandom_range(1, 4));
    plen = int'($urandom_range(1, 14));
    for (int i = 0; i < plen; i++) pay_bytes.push_back(8'($urandom_range(0, 255)));
    add_packet($urandom, n);
  endtask

  // Drive all queued headers, payload beats and downstream ready concurrently
  task automatic apply_stimulus(input int gap, input int rmode);
    hdr_done = 1'b0;
    pay_done = 1'b0;
    fork
      begin
        while (hdr_q.size() > 0) begin
          beat_t h;
          int    cnt;
          h = hdr_q.pop_front();
          valid_insert    = 1'b1;
          data_insert     = h.data;
          keep_insert     = h.keep;
          byte_insert_cnt = 2'($urandom);
          cnt = 0;
          @(negedge clk);
          while (!ready_insert && cnt < LIMIT) begin @(negedge clk); cnt++; end
          @(posedge clk); #1;
          check_output("hdr_wait", 32'(cnt < LIMIT), 32'd1);
          if (gap > 0) begin
            valid_insert = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
          end
        end
        valid_insert = 1'b0;
        hdr_done = 1'b1;
      end
      begin
        while (pay_q.size() > 0) begin
          beat_t p;
          int    cnt;
          p = pay_q.pop_front();
          valid_in = 1'b1;
          data_in  = p.data;
          keep_in  = p.keep;
          last_in  = p.last;
          cnt = 0;
          @(negedge clk);
          while (!ready_in && cnt < LIMIT) begin @(negedge clk); cnt++; end
          @(posedge clk); #1;
          check_output("pay_wait", 32'(cnt < LIMIT), 32'd1);
          if (gap > 0) begin
            valid_in = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
          end
        end
        valid_in = 1'b0;
        pay_done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!(hdr_done && pay_done && exp_q.size() == 0) && c < 4 * LIMIT) begin
          case (rmode)
            1:       ready_out = ($urandom_range(0, 3) != 0);
            2:       ready_out = !(c >= 3 && c < 6);
            default: ready_out = 1'b1;
          endcase
          @(posedge clk); #1;
          c++;
        end
        ready_out = 1'b1;
        check_output("drain", 32'(c < 4 * LIMIT), 32'd1);
      end
    join
  endtask

  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;
  bit          prev_stall, prev_in_hs, hdr_active;

  // Monitor: scoreboard, stall stability, latency and handshake ordering
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_in_hs = 1'b0;
      hdr_active = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_valid", 32'(valid_out), 32'd1);
        check_output("stall_data", data_out, prev_data);
        check_output("stall_keep", 32'(keep_out), 32'(prev_keep));
        check_output("stall_last", 32'(last_out), 32'(prev_last));
      end
      if (prev_in_hs) check_output("latency", 32'(valid_out), 32'd1);
      if (valid_out && !ready_out) check_output("stall_ready_in", 32'(ready_in), 32'd0);
      if (valid_insert && ready_insert) begin
        check_output("hdr_order", 32'(hdr_active), 32'd0);
        hdr_active = 1'b1;
      end
      if (valid_in && ready_in) begin
        check_output("pay_order", 32'(hdr_active), 32'd1);
        if (last_in) hdr_active = 1'b0;
      end
      if (sb_en && valid_out && ready_out) begin
        if (exp_q.size() == 0) check_output("extra_beat", 32'(valid_out), 32'd0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check_output("out_data", data_out, e.data);
          check_output("out_keep", 32'(keep_out), 32'(e.keep));
          check_output("out_last", 32'(last_out), 32'(e.last));
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
      prev_keep  = keep_out;
      prev_last  = last_out;
      prev_in_hs = valid_in && ready_in;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid_out", 32'(valid_out), 32'd0);
    check_output("rst_data_out", data_out, 32'd0);
    check_output("rst_keep_out", 32'(keep_out), 32'd0);
    check_output("rst_last_out", 32'(last_out), 32'd0);
    check_output("rst_ready_in", 32'(ready_in), 32'd0);
    check_output("rst_ready_insert", 32'(ready_insert), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_ready_insert", 32'(ready_insert), 32'd1);
    check_output("idle_ready_in", 32'(ready_in), 32'd0);
    @(posedge clk); #1;

    $display("[TB] 3-byte header, full last beat");
    push_word(32'h11223344, 4); push_word(32'h55667788, 4); push_word(32'h99AABBCC, 4);
    add_packet(32'h00AABBCC, 3);
    apply_stimulus(0, 0);

    $display("[TB] 3-byte header, 3-byte last beat");
    push_word(32'h11223344, 4); push_word(32'h55667788, 4); push_word(32'h99AABBCC, 3);
    add_packet(32'h00AABBCC, 3);
    apply_stimulus(0, 0);

    $display("[TB] full-width header");
    push_word(32'hA1A2A3A4, 4); push_word(32'hB1B2B3B4, 4); push_word(32'hC1C2C3C4, 2);
    add_packet(32'h01020304, 4);
    apply_stimulus(0, 0);

    $display("[TB] downstream stall mid-packet");
    push_word(32'h11223344, 4); push_word(32'h55667788, 4); push_word(32'h99AABBCC, 4);
    add_packet(32'h00AABBCC, 3);
    apply_stimulus(0, 2);

    $display("[TB] back-to-back packets");
    for (int k = 0; k < 5; k++) add_random_packet();
    apply_stimulus(0, 0);

    $display("[TB] reset mid-packet");
    sb_en        = 1'b0;
    ready_out    = 1'b0;
    valid_insert = 1'b1;
    data_insert  = 32'h00000A0B;
    keep_insert  = 4'b0011;
    @(posedge clk); #1;
    valid_insert = 1'b0;
    valid_in     = 1'b1;
    data_in      = 32'hDEADBEEF;
    keep_in      = 4'hF;
    last_in      = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_output("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(valid_out), 32'd0);
    check_output("mid_rst_data", data_out, 32'd0);
    check_output("mid_rst_ready_in", 32'(ready_in), 32'd0);
    check_output("mid_rst_ready_insert", 32'(ready_insert), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_ready_insert", 32'(ready_insert), 32'd1);
    @(posedge clk); #1;
    sb_en     = 1'b1;
    ready_out = 1'b1;
    add_random_packet();
    apply_stimulus(0, 0);

    $display("[TB] random traffic with gaps and backpressure");
    for (int k = 0; k < 30; k++) add_random_packet();
    apply_stimulus(2, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
